// File: rtl/switch_scan_reader.sv
// Serial-to-parallel switch reader driving a 74HC165-style PISO chain.
// Optional two-frame debounce: define SCAN_DEBOUNCE_EN.
module switch_scan_reader #(
    parameter int WIDTH       = 16,
    parameter int CLK_DIV     = 4,
    parameter int LOAD_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_serial,
    output logic             o_load_n,
    output logic             o_sclk,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);

    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("WIDTH must be in 2..32");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("CLK_DIV must be >= 1");
        end
        if (LOAD_CYCLES < 1) begin : g_bad_load
            $error("LOAD_CYCLES must be >= 1");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    load_cnt_q, load_cnt_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             load_n_q, load_n_d;
    logic             sclk_q, sclk_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
`ifdef SCAN_DEBOUNCE_EN
    logic [WIDTH-1:0] raw_q, raw_d;
`endif

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        load_n_d   = load_n_q;
        sclk_d     = sclk_q;
        data_d     = data_q;
        valid_d    = 1'b0;
`ifdef SCAN_DEBOUNCE_EN
        raw_d      = raw_q;
`endif
        unique case (state_q)
            IDLE: begin
                load_n_d = 1'b1;
                sclk_d   = 1'b0;
                if (i_enable) begin
                    state_d    = LOAD;
                    load_n_d   = 1'b0;
                    load_cnt_d = '0;
                end
            end
            LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    state_d  = SHIFT;
                    load_n_d = 1'b1;
                    sclk_d   = 1'b0;
                    bit_d    = '0;
                    div_d    = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    // sample at the end of the low phase, then raise SCLK
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[WIDTH-2:0], i_serial};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = UPDATE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            UPDATE: begin
`ifdef SCAN_DEBOUNCE_EN
                raw_d = sr_q;
                if (sr_q == raw_q) begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                end
`else
                data_d  = sr_q;
                valid_d = 1'b1;
`endif
                if (i_enable) begin
                    state_d    = LOAD;
                    load_n_d   = 1'b0;
                    load_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            load_n_q   <= 1'b1;
            sclk_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
`ifdef SCAN_DEBOUNCE_EN
            raw_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            load_n_q   <= load_n_d;
            sclk_q     <= sclk_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
`ifdef SCAN_DEBOUNCE_EN
            raw_q      <= raw_d;
`endif
        end
    end

    assign o_load_n = load_n_q;
    assign o_sclk   = sclk_q;
    assign o_data   = data_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_switch_scan_reader.sv
// Bench for switch_scan_reader: 165 chain model plus a frame scoreboard.
// Expected frames are queued by stimulus and checked by a monitor.
module tb_switch_scan_reader;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         ser;
    logic         load_n;
    logic         sclk;
    logic [W-1:0] data;
    logic         valid;

    logic [W-1:0] preset = '0;
    logic [W-1:0] chain = '0;
    logic         sclk_prev = 1'b0;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    switch_scan_reader #(
        .WIDTH(W),
        .CLK_DIV(4),
        .LOAD_CYCLES(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_enable(en),
        .i_serial(ser),
        .o_load_n(load_n),
        .o_sclk(sclk),
        .o_data(data),
        .o_valid(valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external 74HC165 chain: parallel load while low, shift on SCLK rise
    always @(posedge clk) begin
        if (!load_n) chain <= preset;
        else if (sclk && !sclk_prev) chain <= {chain[W-2:0], 1'b0};
        sclk_prev <= sclk;
    end
    assign ser = chain[W-1];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid && k < budget);
        if (!valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout got=none want=pulse");
        end
    endtask

    task automatic idle_watch(input string nm, input int n);
        int lo = 0;
        int hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (!load_n) lo++;
            if (sclk) hi++;
        end
        chk({nm, "_load_n_low"}, lo, 0);
        chk({nm, "_sclk_high"}, hi, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid got=%h want=no_pulse", data);
                end else begin
                    e = q.pop_front();
                    if (data !== e.d || cyc != e.c) begin
                        bad++;
                        $display("FAIL frame got=%h@%0d want=%h@%0d",
                                 data, cyc, e.d, e.c);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=hang want=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lo;
        int rises;
        logic ps;
        int k;

        tick(3);
        chk("rst_load_n", load_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        rst = 1'b0;
        tick(2);

`ifdef SCAN_DEBOUNCE_EN
        preset = 16'h1234;
        tick(1);
        en = 1'b1;
        k = cyc;
        push(16'h1234, k + 132 + 131);
        tick(191);
        preset = 16'hFFFF;
        tick(131);
        preset = 16'h1234;
        tick(100);
        en = 1'b0;
        tick(200);
        chk("db_hold_data", data, 16'h1234);
        idle_watch("db_idle", 10);
`else
        // single frame
        preset = 16'hA5C3;
        tick(1);
        en = 1'b1;
        push(16'hA5C3, cyc + 132);
        lo = 0;
        rises = 0;
        ps = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 0) en = 1'b0;
            if (!load_n) lo++;
            if (sclk && !ps) rises++;
            ps = sclk;
            if (valid) break;
        end
        chk("load_low_cycles", lo, 2);
        chk("sclk_rises", rises, 16);
        idle_watch("single_idle", 20);

        // continuous, two frames
        preset = 16'h0001;
        en = 1'b1;
        push(16'h0001, cyc + 132);
        push(16'h8000, cyc + 132 + 131);
        tick(20);
        preset = 16'h8000;
        wait_valid(300);
        en = 1'b0;
        wait_valid(300);
        idle_watch("cont_idle", 30);
        chk("cont_data", data, 16'h8000);

        // drop enable mid-frame
        preset = 16'h3C5A;
        tick(1);
        en = 1'b1;
        push(16'h3C5A, cyc + 132);
        tick(2 + 5 * 8 + 3);
        en = 1'b0;
        wait_valid(300);
        idle_watch("drop_idle", 200);

        // reset mid-frame
        preset = 16'hFFFF;
        tick(1);
        en = 1'b1;
        tick(2 + 7 * 8 + 3);
        rst = 1'b1;
        tick(1);
        chk("abort_load_n", load_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_valid", valid, 0);
        chk("abort_data", data, 0);
        rst = 1'b0;
        push(16'hFFFF, cyc + 132);
        tick(20);
        chk("fresh_data", data, 0);
        en = 1'b0;
        wait_valid(300);
        chk("fresh_final", data, 16'hFFFF);
`endif

        tick(5);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
